// File: rtl/j1_io_pkg.sv
// Shared definitions for the j1 UART IO peripheral: bus select bits,
// STATUS/IE bit positions and the common serial FSM state encoding.
package j1_io_pkg;
   localparam int SEL_DATA   = 12;
   localparam int SEL_STATUS = 13;
   localparam int SEL_IE     = 14;

   localparam int STB_TX_NFULL  = 0;
   localparam int STB_RX_NEMPTY = 1;
   localparam int STB_TX_IDLE   = 2;
   localparam int STB_RXOVR     = 3;
   localparam int STB_FERR      = 4;
   localparam int STB_TXOVR     = 5;

   localparam int IE_RX_NEMPTY = 0;
   localparam int IE_TX_EMPTY  = 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } uart_state_e;
endpackage

// File: rtl/uart_fifo.sv
// Byte FIFO with a registered occupancy count; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module uart_fifo #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_BITS = 4
) (
   input  logic             clk,
   input  logic             resetq,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head,
   output logic             o_full,
   output logic             o_empty
);
   localparam int DEPTH = 1 << DEPTH_BITS;

   logic [WIDTH-1:0]      r_mem [DEPTH];
   logic [DEPTH_BITS-1:0] r_wptr;
   logic [DEPTH_BITS-1:0] r_rptr;
   logic [DEPTH_BITS:0]   r_count;
   logic                  w_do_push;
   logic                  w_do_pop;

   // count tops out at exactly DEPTH, so its MSB alone flags full
   assign o_empty   = (r_count == '0);
   assign o_full    = r_count[DEPTH_BITS];
   assign o_head    = r_mem[r_rptr];
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wptr] <= i_data;
   end

   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + DEPTH_BITS'(1);
         if (w_do_pop)  r_rptr <= r_rptr + DEPTH_BITS'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + (DEPTH_BITS+1)'(1);
            2'b01:   r_count <= r_count - (DEPTH_BITS+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: rtl/j1_uart_io.sv
// Memory-mapped 8N1 UART for the j1 IO bus: DATA/STATUS/IE registers,
// TX and RX byte FIFOs, serial FSMs and a registered level interrupt.
module j1_uart_io
   import j1_io_pkg::*;
#(
   parameter int CLKS_PER_BIT = 104,
   parameter int FIFO_BITS    = 4
) (
   input  logic        clk,
   input  logic        resetq,
   input  logic        io_rd,
   input  logic        io_wr,
   input  logic [31:0] io_addr,
   input  logic [31:0] io_dout,
   output logic [31:0] io_din,
   output logic        interrupt_request,
   input  logic        uart_rx,
   output logic        uart_tx
);
   localparam logic [15:0] CNT_LAST = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] CNT_HALF = 16'(CLKS_PER_BIT / 2 - 1);

   logic        w_sel_data, w_sel_status, w_sel_ie;
   logic        w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
   logic        w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
   logic [7:0]  w_tx_head, w_rx_head;
   logic [31:0] w_status;
   logic        w_tx_bit_end, w_rx_bit_end, w_rx_stop_at;
   logic        w_rxovr_set, w_txovr_set, w_ferr_set, w_sts_wr;
   logic        w_unused_bits;

   uart_state_e r_tx_state, r_rx_state;
   logic [15:0] r_tx_cnt, r_rx_cnt;
   logic [2:0]  r_tx_bit, r_rx_bit;
   logic [7:0]  r_tx_shift, r_rx_shift;
   logic        r_uart_tx;
   logic        r_rx_s1, r_rx_s2, r_rx_s3, r_rx_brk;
   logic        r_rxovr, r_ferr, r_txovr;
   logic [1:0]  r_ie;
   logic        r_irq;

   assign w_sel_data   = io_addr[SEL_DATA];
   assign w_sel_status = io_addr[SEL_STATUS];
   assign w_sel_ie     = io_addr[SEL_IE];
   assign w_unused_bits = ^{io_addr[31:15], io_addr[11:0], io_dout[31:8]};

   assign w_tx_push = io_wr & w_sel_data;
   assign w_rx_pop  = io_rd & w_sel_data;
   assign w_sts_wr  = io_wr & w_sel_status;

   uart_fifo #(.WIDTH(8), .DEPTH_BITS(FIFO_BITS)) u_tx_fifo (
      .clk(clk), .resetq(resetq),
      .i_push(w_tx_push), .i_data(io_dout[7:0]), .i_pop(w_tx_pop),
      .o_head(w_tx_head), .o_full(w_tx_full), .o_empty(w_tx_empty)
   );

   uart_fifo #(.WIDTH(8), .DEPTH_BITS(FIFO_BITS)) u_rx_fifo (
      .clk(clk), .resetq(resetq),
      .i_push(w_rx_push), .i_data(r_rx_shift), .i_pop(w_rx_pop),
      .o_head(w_rx_head), .o_full(w_rx_full), .o_empty(w_rx_empty)
   );

   always_comb begin
      w_status                = '0;
      w_status[STB_TX_NFULL]  = ~w_tx_full;
      w_status[STB_RX_NEMPTY] = ~w_rx_empty;
      w_status[STB_TX_IDLE]   = w_tx_empty & (r_tx_state == S_IDLE);
      w_status[STB_RXOVR]     = r_rxovr;
      w_status[STB_FERR]      = r_ferr;
      w_status[STB_TXOVR]     = r_txovr;
   end

   // The CPU latches io_din on the same edge as io_rd, so this stays combinational
   always_comb begin
      io_din = '0;
      if (w_sel_data && !w_rx_empty) io_din = io_din | {24'b0, w_rx_head};
      if (w_sel_status)              io_din = io_din | w_status;
      if (w_sel_ie)                  io_din = io_din | {30'b0, r_ie};
   end

   assign w_tx_bit_end = (r_tx_cnt == CNT_LAST);
   assign w_tx_pop     = (r_tx_state == S_IDLE) & ~w_tx_empty;
   assign uart_tx      = r_uart_tx;

   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         r_tx_state <= S_IDLE;
         r_tx_cnt   <= '0;
         r_tx_bit   <= '0;
         r_uart_tx  <= 1'b1;
      end else begin
         case (r_tx_state)
            S_IDLE: if (!w_tx_empty) begin
               r_tx_state <= S_START;
               r_tx_cnt   <= '0;
               r_uart_tx  <= 1'b0;
            end
            S_START: if (w_tx_bit_end) begin
               r_tx_state <= S_DATA;
               r_tx_cnt   <= '0;
               r_tx_bit   <= '0;
               r_uart_tx  <= r_tx_shift[0];
            end else r_tx_cnt <= r_tx_cnt + 16'd1;
            S_DATA: if (w_tx_bit_end) begin
               r_tx_cnt <= '0;
               if (r_tx_bit == 3'd7) begin
                  r_tx_state <= S_STOP;
                  r_uart_tx  <= 1'b1;
               end else begin
                  r_tx_bit  <= r_tx_bit + 3'd1;
                  r_uart_tx <= r_tx_shift[1];
               end
            end else r_tx_cnt <= r_tx_cnt + 16'd1;
            S_STOP: if (w_tx_bit_end) begin
               r_tx_state <= S_IDLE;
               r_tx_cnt   <= '0;
            end else r_tx_cnt <= r_tx_cnt + 16'd1;
            default: r_tx_state <= S_IDLE;
         endcase
      end
   end

   // Shifter drops the sent bit at each data-bit boundary; bit 1 is the next to go
   always_ff @(posedge clk) begin
      if (w_tx_pop)                                  r_tx_shift <= w_tx_head;
      else if (r_tx_state == S_DATA && w_tx_bit_end) r_tx_shift <= {1'b0, r_tx_shift[7:1]};
   end

   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         r_rx_s1 <= 1'b1;
         r_rx_s2 <= 1'b1;
         r_rx_s3 <= 1'b1;
      end else begin
         r_rx_s1 <= uart_rx;
         r_rx_s2 <= r_rx_s1;
         r_rx_s3 <= r_rx_s2;
      end
   end

   assign w_rx_bit_end = (r_rx_cnt == CNT_LAST);
   assign w_rx_stop_at = (r_rx_state == S_STOP) & ~r_rx_brk & w_rx_bit_end;
   assign w_rx_push    = w_rx_stop_at & r_rx_s2;
   assign w_ferr_set   = w_rx_stop_at & ~r_rx_s2;

   // After a framing error, r_rx_brk parks the FSM in STOP until the line idles high
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         r_rx_state <= S_IDLE;
         r_rx_cnt   <= '0;
         r_rx_bit   <= '0;
         r_rx_brk   <= 1'b0;
      end else begin
         case (r_rx_state)
            S_IDLE: if (r_rx_s3 && !r_rx_s2) begin
               r_rx_state <= S_START;
               r_rx_cnt   <= '0;
            end
            S_START: if (r_rx_cnt == CNT_HALF) begin
               r_rx_cnt   <= '0;
               r_rx_bit   <= '0;
               r_rx_state <= r_rx_s2 ? S_IDLE : S_DATA;
            end else r_rx_cnt <= r_rx_cnt + 16'd1;
            S_DATA: if (w_rx_bit_end) begin
               r_rx_cnt <= '0;
               if (r_rx_bit == 3'd7) r_rx_state <= S_STOP;
               else                  r_rx_bit   <= r_rx_bit + 3'd1;
            end else r_rx_cnt <= r_rx_cnt + 16'd1;
            S_STOP: if (r_rx_brk) begin
               if (r_rx_s2) begin
                  r_rx_brk   <= 1'b0;
                  r_rx_state <= S_IDLE;
               end
            end else if (w_rx_bit_end) begin
               r_rx_cnt <= '0;
               if (r_rx_s2) r_rx_state <= S_IDLE;
               else         r_rx_brk   <= 1'b1;
            end else r_rx_cnt <= r_rx_cnt + 16'd1;
            default: r_rx_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (r_rx_state == S_DATA && w_rx_bit_end) r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
   end

   assign w_rxovr_set = w_rx_push & w_rx_full & ~w_rx_pop;
   assign w_txovr_set = w_tx_push & w_tx_full & ~w_tx_pop;

   // Set events override a simultaneous write-1-to-clear
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         r_rxovr <= 1'b0;
         r_ferr  <= 1'b0;
         r_txovr <= 1'b0;
         r_ie    <= '0;
         r_irq   <= 1'b0;
      end else begin
         r_rxovr <= w_rxovr_set | (r_rxovr & ~(w_sts_wr & io_dout[STB_RXOVR]));
         r_ferr  <= w_ferr_set  | (r_ferr  & ~(w_sts_wr & io_dout[STB_FERR]));
         r_txovr <= w_txovr_set | (r_txovr & ~(w_sts_wr & io_dout[STB_TXOVR]));
         if (io_wr && w_sel_ie) r_ie <= io_dout[1:0];
         r_irq <= (r_ie[IE_RX_NEMPTY] & ~w_rx_empty) | (r_ie[IE_TX_EMPTY] & w_tx_empty);
      end
   end

   assign interrupt_request = r_irq;
endmodule

// File: tb/tb_j1_uart_io.sv
// Scoreboard bench for j1_uart_io: bus reads and serial TX frames are checked
// by monitors against expectations queued from a queue-based reference model.
module tb_j1_uart_io;
   localparam int CPB = 8;
   localparam int FB  = 4;
   localparam logic [31:0] A_DATA   = 32'h0000_1000;
   localparam logic [31:0] A_STATUS = 32'h0000_2000;
   localparam logic [31:0] A_IE     = 32'h0000_4000;

   logic        clk = 1'b0;
   logic        resetq;
   logic        io_rd, io_wr;
   logic [31:0] io_addr, io_dout, io_din;
   logic        interrupt_request;
   logic        uart_rx, uart_tx;

   j1_uart_io #(.CLKS_PER_BIT(CPB), .FIFO_BITS(FB)) dut (
      .clk(clk), .resetq(resetq), .io_rd(io_rd), .io_wr(io_wr),
      .io_addr(io_addr), .io_dout(io_dout), .io_din(io_din),
      .interrupt_request(interrupt_request), .uart_rx(uart_rx), .uart_tx(uart_tx)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errs   = 0;

   logic [31:0] exp_q[$];
   logic [31:0] exp_addr_q[$];
   logic [7:0]  tx_exp[$];
   logic        mon_en = 1'b0;
   logic        tx_mon_on = 1'b1;
   logic [9:0]  mon_bits;

   // reference model state
   logic [7:0]  m_rxq[$];
   logic        m_rxovr = 1'b0, m_ferr = 1'b0, m_txovr = 1'b0;

   function automatic logic [31:0] m_status();
      return {26'b0, m_txovr, m_ferr, m_rxovr, 1'b1, (m_rxq.size() != 0), 1'b1};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_errs++;
         $display("FAIL %s: got %h, expected %h", name, act, expv);
      end
   endtask

   task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
      io_addr = a; io_dout = d; io_wr = 1'b1;
      @(posedge clk); #1;
      io_wr = 1'b0; io_addr = '0; io_dout = '0;
   endtask

   task automatic bus_rd(input logic [31:0] a, input logic [31:0] expv);
      exp_q.push_back(expv);
      exp_addr_q.push_back(a);
      io_addr = a; io_rd = 1'b1; mon_en = 1'b1;
      @(posedge clk); #1;
      io_rd = 1'b0; mon_en = 1'b0; io_addr = '0;
   endtask

   task automatic rd_data();
      logic [31:0] e;
      e = (m_rxq.size() != 0) ? {24'b0, m_rxq.pop_front()} : 32'h0;
      bus_rd(A_DATA, e);
   endtask

   task automatic status_raw(output logic [31:0] v);
      io_addr = A_STATUS;
      @(negedge clk); v = io_din;
      @(posedge clk); #1;
      io_addr = '0;
   endtask

   task automatic wait_tx_idle();
      logic [31:0] v;
      for (int i = 0; i < 3000; i++) begin
         status_raw(v);
         if (v[2]) return;
      end
      n_checks++; n_errs++;
      $display("FAIL tx-idle-timeout: got busy, expected idle within 3000 cycles");
   endtask

   task automatic rx_frame(input logic [7:0] b, input logic stop);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      for (int k = 0; k < 10; k++) begin
         uart_rx = f[k];
         repeat (CPB) @(posedge clk);
         #1;
      end
      uart_rx = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      if (!stop)              m_ferr = 1'b1;
      else if (m_rxq.size() < (1 << FB)) m_rxq.push_back(b);
      else                    m_rxovr = 1'b1;
   endtask

   initial begin
      logic [31:0] v;
      logic [7:0]  b;
      fork
         forever begin
            @(negedge clk);
            if (io_rd && mon_en) begin
               if (exp_q.size() == 0) begin
                  n_checks++; n_errs++;
                  $display("FAIL read-unexpected: got %h, expected no read", io_din);
               end else begin
                  $sformat(v, "%0s", "");
                  chk($sformatf("read@%h", exp_addr_q.pop_front()), io_din, exp_q.pop_front());
               end
            end
         end
         forever begin
            @(negedge uart_tx);
            if (tx_mon_on && resetq) begin
               repeat (CPB / 2) @(posedge clk);
               #1 mon_bits[0] = uart_tx;
               for (int k = 1; k < 10; k++) begin
                  repeat (CPB) @(posedge clk);
                  #1 mon_bits[k] = uart_tx;
               end
               chk("tx-start", {31'b0, mon_bits[0]}, 32'h0);
               chk("tx-stop",  {31'b0, mon_bits[9]}, 32'h1);
               if (tx_exp.size() == 0) begin
                  n_checks++; n_errs++;
                  $display("FAIL tx-unexpected: got byte %h, expected none", mon_bits[8:1]);
               end else chk("tx-byte", {24'b0, mon_bits[8:1]}, {24'b0, tx_exp.pop_front()});
            end
         end
         begin
            #1_000_000;
            $display("FAIL watchdog: got timeout, expected completion");
            $fatal(1, "watchdog");
         end
      join_none

      resetq = 1'b0; io_rd = 1'b0; io_wr = 1'b0; io_addr = '0; io_dout = '0; uart_rx = 1'b1;
      #23;
      chk("rst-uart_tx", {31'b0, uart_tx}, 32'h1);
      chk("rst-irq", {31'b0, interrupt_request}, 32'h0);
      chk("rst-io_din", io_din, 32'h0);
      @(posedge clk); #1 resetq = 1'b1;
      bus_rd(A_STATUS, m_status());
      bus_rd(A_IE, 32'h0);
      bus_rd(32'h0000_0001, 32'h0);

      // TX 0x55 frame
      tx_exp.push_back(8'h55);
      bus_wr(A_DATA, 32'h55);
      status_raw(v);
      chk("tx-busy-status", {31'b0, v[2]}, 32'h0);
      wait_tx_idle();

      // RX 0xA3
      rx_frame(8'hA3, 1'b1);
      bus_rd(A_STATUS, m_status());
      rd_data();
      bus_rd(A_STATUS, m_status());

      // randomized TX/RX traffic
      for (int i = 0; i < 8; i++) begin
         b = 8'($urandom_range(0, 255));
         tx_exp.push_back(b);
         bus_wr(A_DATA, {24'b0, b});
         rx_frame(8'($urandom_range(0, 255)), 1'b1);
         if ($urandom_range(0, 1) == 1) rd_data();
      end
      wait_tx_idle();
      bus_rd(A_STATUS, m_status());
      while (m_rxq.size() != 0) rd_data();
      rd_data();

      // RX overflow: 17 bytes into a 16-deep FIFO
      for (int i = 0; i < (1 << FB) + 1; i++) rx_frame(8'($urandom_range(0, 255)), 1'b1);
      bus_rd(A_STATUS, m_status());
      for (int i = 0; i < (1 << FB); i++) rd_data();
      bus_rd(A_STATUS, m_status());
      bus_wr(A_STATUS, 32'h8); m_rxovr = 1'b0;
      bus_rd(A_STATUS, m_status());

      // framing error, then a short glitch
      rx_frame(8'h5A, 1'b0);
      bus_rd(A_STATUS, m_status());
      rd_data();
      bus_wr(A_STATUS, 32'h10); m_ferr = 1'b0;
      uart_rx = 1'b0;
      repeat (2) @(posedge clk);
      #1 uart_rx = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      bus_rd(A_STATUS, m_status());

      // TX overflow: the shifter takes one byte, the FIFO holds 16 more
      for (int i = 0; i < (1 << FB) + 2; i++) begin
         b = 8'($urandom_range(0, 255));
         bus_wr(A_DATA, {24'b0, b});
         if (i < (1 << FB) + 1) tx_exp.push_back(b);
         else                   m_txovr = 1'b1;
      end
      status_raw(v);
      chk("tx-full-status", v & 32'h21, 32'h20);
      wait_tx_idle();
      bus_rd(A_STATUS, m_status());
      bus_wr(A_STATUS, 32'h20); m_txovr = 1'b0;
      bus_rd(A_STATUS | A_IE, m_status());

      // interrupts
      bus_wr(A_IE, 32'h1);
      bus_rd(A_IE, 32'h1);
      rx_frame(8'hC6, 1'b1);
      chk("irq-rx", {31'b0, interrupt_request}, 32'h1);
      rd_data();
      @(negedge clk);
      chk("irq-still-high", {31'b0, interrupt_request}, 32'h1);
      @(negedge clk);
      chk("irq-fall", {31'b0, interrupt_request}, 32'h0);
      @(posedge clk); #1;
      bus_wr(A_IE, 32'h2);
      repeat (20) @(posedge clk);
      #1;
      chk("irq-tx-empty", {31'b0, interrupt_request}, 32'h1);
      bus_rd(A_STATUS | A_IE, m_status() | 32'h2);

      // reset in the middle of a TX frame
      tx_mon_on = 1'b0;
      bus_wr(A_DATA, 32'h00);
      repeat (20) @(posedge clk);
      #1;
      chk("tx-midframe", {31'b0, uart_tx}, 32'h0);
      #1 resetq = 1'b0;
      #1;
      chk("tx-async-reset", {31'b0, uart_tx}, 32'h1);
      chk("irq-async-reset", {31'b0, interrupt_request}, 32'h0);
      @(posedge clk); #1 resetq = 1'b1;
      m_rxq.delete(); m_rxovr = 1'b0; m_ferr = 1'b0; m_txovr = 1'b0;
      bus_rd(A_STATUS, m_status());
      bus_rd(A_IE, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      chk("irq-after-reset", {31'b0, interrupt_request}, 32'h0);
      tx_mon_on = 1'b1;

      repeat (4) @(posedge clk);
      #1;
      chk("tx-queue-drained", tx_exp.size(), 32'h0);
      chk("read-queue-drained", exp_q.size(), 32'h0);
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end
endmodule
